div_issue_ctrl: RTL and testbench
=================================

Name: div_issue_ctrl

Overview:
Execute-stage initiator for the iterative divider. It accepts a DIV/DIVU/REM/REMU instruction from the ex stage and latches its operands. It drives and holds the divider start/operand interface, stalls the pipeline while the divide runs, and writes the result back to the register file. It also handles flush cancellation, divide-unit timeout, and x0 destination suppression.

Parameters:
TIMEOUT_CYCLES, 40, maximum BUSY cycles to wait for div_ready_i before aborting (must be ≥ 36)
CNT_WIDTH, 6, width of the BUSY-cycle counter (must hold TIMEOUT_CYCLES)

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous active-low
inst_valid_i  input  1  ex-stage instruction valid
is_div_i  input  1  instruction is DIV/DIVU/REM/REMU
funct3_i  input  3  `FUNCT3_WIDTH op code (`INST_DIV/DIVU/REM/REMU)
rs1_data_i  input  32  dividend
rs2_data_i  input  32  divisor
rd_addr_i  input  5  destination register
flush_i  input  1  pipeline flush (jump/exception)
div_result_i  input  32  divider result
div_ready_i  input  1  divider done pulse
div_busy_i  input  1  divider busy
div_start_o  output  1  divider start (held for the whole operation)
div_dividend_o  output  32  dividend to divider
div_divisor_o  output  32  divisor to divider
div_op_o  output  3  op to divider
hold_o  output  1  pipeline stall request
wb_we_o  output  1  register write enable
wb_addr_o  output  5  register write address
wb_data_o  output  32  register write data
err_o  output  1  one-cycle timeout abort pulse

Behaviour:
- Reset (rst_n low at posedge): state=IDLE; all registered outputs, operand latches and counter are 0. div_start_o and hold_o are 0 during and after reset.
- A request is inst_valid_i & is_div_i & !flush_i.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Request and !div_busy_i: latch rs1, rs2, funct3, rd; clear counter; go to BUSY. hold_o=1 combinationally in this cycle.
  - Request and div_busy_i: stay in IDLE with hold_o=1 and latch nothing.
  - No request: hold_o=0.
- BUSY:
  - div_start_o = !div_ready_i & !flush_i (combinational). This stops the divider re-sampling in its done cycle.
  - div_dividend_o, div_divisor_o and div_op_o come from the latches; they are 0 outside BUSY.
  - hold_o=1. The counter increments every cycle.
  - div_ready_i: latch div_result_i; go to DONE.
  - flush_i (higher priority than ready): go to IDLE, no writeback, hold_o=0 in that cycle.
  - Counter reaches TIMEOUT_CYCLES-1 without ready: go to IDLE; err_o=1 for the next cycle; no writeback.
- DONE (one cycle):
  - wb_we_o=1 unless the latched rd==0. wb_addr_o=latched rd; wb_data_o=latched result. hold_o=0. Go to IDLE.
  - wb_we_o, err_o and wb_data_o are registered; wb_data_o is 0 when wb_we_o=0.
- Latency, counted from the accept cycle A:
  - div_start_o first high at A+1.
  - Divisor 0: div_ready_i at A+3, write at A+4.
  - Nonzero divisor: div_ready_i at A+36, write at A+37.
  - hold_o is high from A through the ready cycle inclusive.
- Back-to-back: a new request is evaluated only in IDLE, i.e. from the cycle after DONE, so the earliest next accept is A+38 for a nonzero divisor.
- Operand, sign and divide-by-zero semantics are the divider's. This block passes operands unmodified.
- Reset mid-operation aborts silently: start drops, no writeback, no err_o.

Test Plan:
- DIVU 100/7, rd=5 at cycle A → div_start_o high A+1..A+35, low at A+36. wb_we_o=1, wb_addr_o=5, wb_data_o=14 at A+37. hold_o high A..A+36.
- DIV 0xFFFFFF9C(-100)/7 → wb_data_o=0xFFFFFFF2 (-14). REM same operands → 0xFFFFFFFE (-2).
- DIVU 5/0 → wb_data_o=0xFFFFFFFF at A+4. REMU 5/0 → wb_data_o=5. hold_o low from A+4.
- DIV with flush_i pulsed at A+10 → div_start_o=0 and hold_o=0 at A+10. No wb_we_o afterwards. A new request at A+12 completes correctly.
- rd=0 DIVU 9/3 → no wb_we_o pulse, hold_o releases normally.
- Stub divider that never asserts ready → err_o pulse at A+TIMEOUT_CYCLES+1, no write, IDLE after. rst_n low mid-BUSY → all outputs 0 next cycle.

Source files
------------

// File: rtl/div_issue_ctrl.sv
// ---------------------------------------------------------------------------
// div_issue_ctrl
//   Execute-stage initiator for the iterative divider. Accepts a
//   DIV/DIVU/REM/REMU from the ex stage, latches its operands, holds the
//   divider start/operand interface for the whole operation, stalls the
//   pipeline while the divide runs and writes the result back. Handles
//   flush cancellation, divide-unit timeout and x0 destination suppression.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | waiting for a divide request (only state that accepts one)
//   BUSY   | divider running; start held, pipeline stalled, timeout armed
//   DONE   | one-cycle register-file write of the latched result
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   inst_valid_i        ex-stage instruction valid
//   is_div_i            instruction is DIV/DIVU/REM/REMU
//   funct3_i            divide op code
//   rs1_data_i          dividend
//   rs2_data_i          divisor
//   rd_addr_i           destination register
//   flush_i             pipeline flush
//   div_result_i        divider result
//   div_ready_i         divider done pulse
//   div_busy_i          divider busy
//   div_start_o         divider start, held through the operation
//   div_dividend_o      dividend to divider (0 outside BUSY)
//   div_divisor_o       divisor to divider (0 outside BUSY)
//   div_op_o            op to divider (0 outside BUSY)
//   hold_o              pipeline stall request
//   wb_we_o             register write enable
//   wb_addr_o           register write address
//   wb_data_o           register write data (0 when wb_we_o is low)
//   err_o               one-cycle timeout abort pulse
// ---------------------------------------------------------------------------
module div_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = 40,
  parameter int CNT_WIDTH      = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_valid_i,
  input  logic        is_div_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        flush_i,
  input  logic [31:0] div_result_i,
  input  logic        div_ready_i,
  input  logic        div_busy_i,
  output logic        div_start_o,
  output logic [31:0] div_dividend_o,
  output logic [31:0] div_divisor_o,
  output logic [2:0]  div_op_o,
  output logic        hold_o,
  output logic        wb_we_o,
  output logic [4:0]  wb_addr_o,
  output logic [31:0] wb_data_o,
  output logic        err_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [1:0]           state_q;
  logic [31:0]          rs1_q;
  logic [31:0]          rs2_q;
  logic [2:0]           op_q;
  logic [4:0]           rd_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 wb_we_q;
  logic [31:0]          wb_data_q;
  logic                 err_q;

  logic req;
  logic in_idle;
  logic in_busy;

  assign req = inst_valid_i & is_div_i & ~flush_i;

  // Combinational outputs are gated by rst_n so start/hold drop in the
  // reset cycle itself, not one cycle later.
  assign in_idle = rst_n & (state_q == S_IDLE);
  assign in_busy = rst_n & (state_q == S_BUSY);

  // Start drops in the ready cycle so the divider does not re-sample.
  assign div_start_o    = in_busy & ~div_ready_i & ~flush_i;
  assign div_dividend_o = in_busy ? rs1_q : 32'd0;
  assign div_divisor_o  = in_busy ? rs2_q : 32'd0;
  assign div_op_o       = in_busy ? op_q  : 3'd0;

  // A request stalls even when the divider is busy and nothing is latched.
  assign hold_o = (in_idle & req) | (in_busy & ~flush_i);

  assign wb_we_o   = wb_we_q;
  assign wb_data_o = wb_data_q;
  assign wb_addr_o = (state_q == S_DONE) ? rd_q : 5'd0;
  assign err_o     = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rs1_q     <= 32'd0;
      rs2_q     <= 32'd0;
      op_q      <= 3'd0;
      rd_q      <= 5'd0;
      cnt_q     <= '0;
      wb_we_q   <= 1'b0;
      wb_data_q <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req && !div_busy_i) begin
            rs1_q   <= rs1_data_i;
            rs2_q   <= rs2_data_i;
            op_q    <= funct3_i;
            rd_q    <= rd_addr_i;
            cnt_q   <= '0;
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          cnt_q <= cnt_q + 1'b1;
          if (flush_i) begin
            state_q <= S_IDLE;
          end else if (div_ready_i) begin
            // Write enable and data are registered here so they appear
            // during DONE; x0 destinations never raise the enable.
            wb_we_q   <= (rd_q != 5'd0);
            wb_data_q <= (rd_q != 5'd0) ? div_result_i : 32'd0;
            state_q   <= S_DONE;
          end else if (cnt_q == CNT_LAST) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        S_DONE: begin
          wb_we_q   <= 1'b0;
          wb_data_q <= 32'd0;
          state_q   <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
module tb_div_issue_ctrl;

  localparam int TIMEOUT = 40;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inst_valid_i, is_div_i, flush_i;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_data_i, rs2_data_i;
  logic [4:0]  rd_addr_i;
  logic [31:0] div_result_i;
  logic        div_ready_i, div_busy_i;
  logic        div_start_o;
  logic [31:0] div_dividend_o, div_divisor_o;
  logic [2:0]  div_op_o;
  logic        hold_o, wb_we_o, err_o;
  logic [4:0]  wb_addr_o;
  logic [31:0] wb_data_o;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [4:0]  addr_q[$];

  // divider stub state
  logic        stub_act;
  logic        stub_hang;
  logic        force_busy;
  int          stub_n;
  logic [31:0] stub_a, stub_b;
  logic [2:0]  stub_op;

  always #5 clk = ~clk;

  div_issue_ctrl #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_WIDTH(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_valid_i(inst_valid_i), .is_div_i(is_div_i), .funct3_i(funct3_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .rd_addr_i(rd_addr_i),
    .flush_i(flush_i), .div_result_i(div_result_i), .div_ready_i(div_ready_i),
    .div_busy_i(div_busy_i), .div_start_o(div_start_o),
    .div_dividend_o(div_dividend_o), .div_divisor_o(div_divisor_o),
    .div_op_o(div_op_o), .hold_o(hold_o), .wb_we_o(wb_we_o),
    .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .err_o(err_o)
  );

  function automatic logic [31:0] ref_div(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic        ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'b100:  return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
      3'b101:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110:  return (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Iterative divider stub: samples start, ready 3 cycles after accept for
  // a zero divisor, 36 otherwise; aborts if start drops early.
  assign div_busy_i = stub_act | force_busy;

  always @(posedge clk) begin
    if (!rst_n) begin
      stub_act     <= 1'b0;
      div_ready_i  <= 1'b0;
      div_result_i <= 32'd0;
      stub_n       <= 0;
    end else if (!stub_act) begin
      div_ready_i <= 1'b0;
      if (div_start_o) begin
        stub_act <= 1'b1;
        stub_n   <= 2;
        stub_a   <= div_dividend_o;
        stub_b   <= div_divisor_o;
        stub_op  <= div_op_o;
      end
    end else if (div_ready_i) begin
      stub_act    <= 1'b0;
      div_ready_i <= 1'b0;
    end else if (!div_start_o) begin
      stub_act <= 1'b0;
    end else begin
      stub_n <= stub_n + 1;
      if (!stub_hang && (stub_n + 1 == ((stub_b == 0) ? 3 : 36))) begin
        div_ready_i  <= 1'b1;
        div_result_i <= ref_div(stub_op, stub_a, stub_b);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    inst_valid_i = 1'b0;
    is_div_i     = 1'b0;
    funct3_i     = 3'd0;
    rs1_data_i   = 32'd0;
    rs2_data_i   = 32'd0;
    rd_addr_i    = 5'd0;
  endtask

  // Issue one divide at the current cycle (A) and check every cycle up to
  // the following idle cycle. flush_at < 0 means no flush.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int flush_at, input bit hang);
    int          lat, last;
    logic        e_start, e_hold, e_we, e_err;
    logic [31:0] d;
    logic [4:0]  ad;
    lat       = (b == 0) ? 3 : 36;
    stub_hang = hang;
    if (hang) last = TIMEOUT + 2;
    else if (flush_at >= 0) last = flush_at + 1;
    else last = lat + 2;
    if (!hang && flush_at < 0 && rd != 0) begin
      exp_q.push_back(ref_div(f, a, b));
      addr_q.push_back(rd);
    end
    inst_valid_i = 1'b1; is_div_i = 1'b1; funct3_i = f;
    rs1_data_i = a; rs2_data_i = b; rd_addr_i = rd;
    for (int t = 0; t <= last; t++) begin
      flush_i = (t == flush_at);
      @(negedge clk);
      if (hang) begin
        e_start = (t >= 1) && (t <= TIMEOUT);
        e_hold  = (t <= TIMEOUT);
        e_we    = 1'b0;
        e_err   = (t == TIMEOUT + 1);
      end else if (flush_at >= 0 && t >= flush_at) begin
        e_start = 1'b0; e_hold = 1'b0; e_we = 1'b0; e_err = 1'b0;
      end else begin
        e_start = (t >= 1) && (t < lat);
        e_hold  = (t <= lat);
        e_we    = (t == lat + 1) && (rd != 0);
        e_err   = 1'b0;
      end
      chk($sformatf("start t=%0d", t), 32'(div_start_o), 32'(e_start));
      chk($sformatf("hold t=%0d", t), 32'(hold_o), 32'(e_hold));
      chk($sformatf("we t=%0d", t), 32'(wb_we_o), 32'(e_we));
      chk($sformatf("err t=%0d", t), 32'(err_o), 32'(e_err));
      if (e_we) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
          d  = exp_q.pop_front();
          ad = addr_q.pop_front();
          chk("wb_data", wb_data_o, d);
          chk("wb_addr", 32'(wb_addr_o), 32'(ad));
        end
      end else begin
        chk($sformatf("wb_data_zero t=%0d", t), wb_data_o, 32'd0);
      end
      if (t == 1) begin
        chk("dividend", div_dividend_o, a);
        chk("divisor", div_divisor_o, b);
        chk("op", 32'(div_op_o), 32'(f));
      end
      step();
      if (t == 0) clear_inputs();
    end
    flush_i   = 1'b0;
    stub_hang = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; force_busy = 1'b0; stub_hang = 1'b0;
    clear_inputs();
    step(); step();
    @(negedge clk);
    chk("rst_start", 32'(div_start_o), 32'd0);
    chk("rst_hold", 32'(hold_o), 32'd0);
    chk("rst_we", 32'(wb_we_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_data", wb_data_o, 32'd0);
    chk("rst_dividend", div_dividend_o, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    run_op(3'b101, 32'd100, 32'd7, 5'd5, -1, 1'b0);            // DIVU 100/7 = 14
    run_op(3'b100, 32'hFFFF_FF9C, 32'd7, 5'd6, -1, 1'b0);      // DIV -100/7 = -14
    run_op(3'b110, 32'hFFFF_FF9C, 32'd7, 5'd7, -1, 1'b0);      // REM -100/7 = -2
    run_op(3'b101, 32'd5, 32'd0, 5'd8, -1, 1'b0);              // DIVU 5/0
    run_op(3'b111, 32'd5, 32'd0, 5'd9, -1, 1'b0);              // REMU 5/0
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd31, -1, 1'b0);
    run_op(3'b100, 32'd1234, 32'd11, 5'd10, 10, 1'b0);         // flushed at A+10
    run_op(3'b111, 32'd1000, 32'd7, 5'd11, -1, 1'b0);          // accepted at A+12
    run_op(3'b101, 32'd9, 32'd3, 5'd0, -1, 1'b0);              // rd=x0
    run_op(3'b101, 32'd77, 32'd5, 5'd12, -1, 1'b1);            // timeout

    // request while divider busy: stall without accepting
    force_busy   = 1'b1;
    inst_valid_i = 1'b1; is_div_i = 1'b1; funct3_i = 3'b101;
    rs1_data_i = 32'd50; rs2_data_i = 32'd6; rd_addr_i = 5'd13;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      chk($sformatf("busy_hold t=%0d", t), 32'(hold_o), 32'd1);
      chk($sformatf("busy_start t=%0d", t), 32'(div_start_o), 32'd0);
      chk($sformatf("busy_dividend t=%0d", t), div_dividend_o, 32'd0);
      step();
    end
    force_busy = 1'b0;
    run_op(3'b101, 32'd50, 32'd6, 5'd13, -1, 1'b0);

    // reset in the middle of BUSY aborts silently
    inst_valid_i = 1'b1; is_div_i = 1'b1; funct3_i = 3'b101;
    rs1_data_i = 32'd300; rs2_data_i = 32'd9; rd_addr_i = 5'd14;
    step();
    clear_inputs();
    for (int t = 1; t < 10; t++) step();
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_start_during", 32'(div_start_o), 32'd0);
    chk("midrst_hold_during", 32'(hold_o), 32'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_start", 32'(div_start_o), 32'd0);
    chk("midrst_hold", 32'(hold_o), 32'd0);
    chk("midrst_we", 32'(wb_we_o), 32'd0);
    chk("midrst_err", 32'(err_o), 32'd0);
    chk("midrst_data", wb_data_o, 32'd0);
    chk("midrst_dividend", div_dividend_o, 32'd0);
    for (int t = 0; t < 40; t++) begin
      step();
      @(negedge clk);
      chk($sformatf("postrst_we t=%0d", t), 32'(wb_we_o), 32'd0);
      chk($sformatf("postrst_err t=%0d", t), 32'(err_o), 32'd0);
    end
    step();
    run_op(3'b100, 32'd42, 32'hFFFF_FFFA, 5'd15, -1, 1'b0);   // DIV 42/-6 = -7

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
